// File: rtl/demux_pkg.sv
// Shared constants for the buffered 1-to-2 demux.
// Channel select codes, slot state encoding, default width.
package demux_pkg;

   localparam logic CH_A = 1'b0;
   localparam logic CH_B = 1'b1;

   localparam int DEF_WIDTH = 4;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_t;

endpackage

// File: rtl/demux_4bit_1to2_buf_if.sv
// Handshake bundle for demux_4bit_1to2_buf.
// Counter signals exist only when DEMUX_STATS_EN is defined.
interface demux_4bit_1to2_buf_if #(
   parameter int WIDTH = 4
`ifdef DEMUX_STATS_EN
  ,parameter int CNT_W = 8
`endif
);

   logic [WIDTH-1:0] in_data;
   logic             in_sel;
   logic             in_valid;
   logic             in_ready;

   logic [WIDTH-1:0] outA_data;
   logic             outA_valid;
   logic             outA_ready;

   logic [WIDTH-1:0] outB_data;
   logic             outB_valid;
   logic             outB_ready;

`ifdef DEMUX_STATS_EN
   logic [CNT_W-1:0] cntA;
   logic [CNT_W-1:0] cntB;
`endif

   modport master (
      output in_data, in_sel, in_valid,
      input  in_ready,
      input  outA_data, outA_valid,
      output outA_ready,
      input  outB_data, outB_valid,
      output outB_ready
`ifdef DEMUX_STATS_EN
     ,input  cntA, cntB
`endif
   );

   modport slave (
      input  in_data, in_sel, in_valid,
      output in_ready,
      output outA_data, outA_valid,
      input  outA_ready,
      output outB_data, outB_valid,
      input  outB_ready
`ifdef DEMUX_STATS_EN
     ,output cntA, cntB
`endif
   );

endinterface

// File: rtl/demux_slot.sv
// One-entry valid/ready holding register.
// Load may coincide with a drain; new word replaces the old.
module demux_slot
   import demux_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             valid,
   input  logic             ready
);

   slot_state_t      state, state_nxt;
   logic [WIDTH-1:0] data_q;

   // slot state register, emptied asynchronously on reset
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) state <= SLOT_EMPTY;
      else     state <= state_nxt;
   end

   // next state: load wins, otherwise drain empties a full slot
   always_comb begin
      state_nxt = state;
      unique case (state)
         SLOT_EMPTY: if (load) state_nxt = SLOT_FULL;
         SLOT_FULL: begin
            if (load)       state_nxt = SLOT_FULL;
            else if (ready) state_nxt = SLOT_EMPTY;
         end
         default: state_nxt = SLOT_EMPTY;
      endcase
   end

   // data capture only on load so a stalled word stays stable
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst)       data_q <= '0;
      else if (load) data_q <= din;
   end

   assign dout  = data_q;
   assign valid = (state == SLOT_FULL);

endmodule

// File: rtl/demux_4bit_1to2_buf.sv
// Buffered 1-to-2 demux with per-channel holding slots.
// Optional per-channel delivery counters under DEMUX_STATS_EN.
module demux_4bit_1to2_buf
   import demux_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
`ifdef DEMUX_STATS_EN
  ,parameter int CNT_W = 8
`endif
) (
   input logic Clk,
   input logic Rst,
   demux_4bit_1to2_buf_if.slave bus
);

   logic sel_valid;
   logic sel_ready;
   logic xfer;
   logic load_a;
   logic load_b;

   // readiness follows only the addressed channel, never in_valid
   always_comb begin
      sel_valid = bus.outA_valid;
      sel_ready = bus.outA_ready;
      if (bus.in_sel == CH_B) begin
         sel_valid = bus.outB_valid;
         sel_ready = bus.outB_ready;
      end
   end

   assign bus.in_ready = !sel_valid || sel_ready;
   assign xfer   = bus.in_valid && bus.in_ready;
   assign load_a = xfer && (bus.in_sel == CH_A);
   assign load_b = xfer && (bus.in_sel == CH_B);

   demux_slot #(.WIDTH(WIDTH)) u_slot_a (
      .Clk   (Clk),
      .Rst   (Rst),
      .load  (load_a),
      .din   (bus.in_data),
      .dout  (bus.outA_data),
      .valid (bus.outA_valid),
      .ready (bus.outA_ready)
   );

   demux_slot #(.WIDTH(WIDTH)) u_slot_b (
      .Clk   (Clk),
      .Rst   (Rst),
      .load  (load_b),
      .din   (bus.in_data),
      .dout  (bus.outB_data),
      .valid (bus.outB_valid),
      .ready (bus.outB_ready)
   );

`ifdef DEMUX_STATS_EN
   logic [CNT_W-1:0] cnt_a;
   logic [CNT_W-1:0] cnt_b;

   // saturating count of words delivered on each channel
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         cnt_a <= '0;
         cnt_b <= '0;
      end else begin
         if (bus.outA_valid && bus.outA_ready && cnt_a != '1)
            cnt_a <= cnt_a + 1'b1;
         if (bus.outB_valid && bus.outB_ready && cnt_b != '1)
            cnt_b <= cnt_b + 1'b1;
      end
   end

   assign bus.cntA = cnt_a;
   assign bus.cntB = cnt_b;
`endif

endmodule

// File: tb/tb_demux_4bit_1to2_buf.sv
// Directed self-checking bench for demux_4bit_1to2_buf.
// Stats check runs only when DEMUX_STATS_EN is defined (CNT_W=2).
module tb_demux_4bit_1to2_buf;

   logic Clk;
   logic Rst;
   int   n_pass;
   int   n_tot;

`ifdef DEMUX_STATS_EN
   demux_4bit_1to2_buf_if #(.WIDTH(4), .CNT_W(2)) bif ();
   demux_4bit_1to2_buf #(.WIDTH(4), .CNT_W(2)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bif.slave)
   );
`else
   demux_4bit_1to2_buf_if #(.WIDTH(4)) bif ();
   demux_4bit_1to2_buf #(.WIDTH(4)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bif.slave)
   );
`endif

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_tot++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] d, input logic s,
                        input logic v);
      bif.in_data  = d;
      bif.in_sel   = s;
      bif.in_valid = v;
      #1;
   endtask

   initial begin
      n_pass = 0;
      n_tot  = 0;
      Rst = 1'b1;
      bif.in_data = 4'h0;
      bif.in_sel = 1'b0;
      bif.in_valid = 1'b0;
      bif.outA_ready = 1'b0;
      bif.outB_ready = 1'b0;
      tick();
      tick();
      Rst = 1'b0;
      #1;
      check("rst_a_valid", 32'(bif.outA_valid), 32'd0);
      check("rst_b_valid", 32'(bif.outB_valid), 32'd0);
      check("rst_a_data", 32'(bif.outA_data), 32'h0);
      check("rst_b_data", 32'(bif.outB_data), 32'h0);
      check("rst_in_ready", 32'(bif.in_ready), 32'd1);

      // basic routing
      bif.outA_ready = 1'b1;
      bif.outB_ready = 1'b1;
      drive(4'hA, 1'b0, 1'b1);
      check("rt_ready0", 32'(bif.in_ready), 32'd1);
      tick();
      check("rt_a_valid", 32'(bif.outA_valid), 32'd1);
      check("rt_a_data", 32'(bif.outA_data), 32'hA);
      check("rt_b_idle", 32'(bif.outB_valid), 32'd0);
      drive(4'h5, 1'b1, 1'b1);
      tick();
      check("rt_b_valid", 32'(bif.outB_valid), 32'd1);
      check("rt_b_data", 32'(bif.outB_data), 32'h5);
      check("rt_a_drained", 32'(bif.outA_valid), 32'd0);
      drive(4'h0, 1'b0, 1'b0);
      tick();
      check("rt_b_drained", 32'(bif.outB_valid), 32'd0);

      // back-pressure on A
      bif.outA_ready = 1'b0;
      drive(4'h3, 1'b0, 1'b1);
      tick();
      check("bp_a_data", 32'(bif.outA_data), 32'h3);
      drive(4'h7, 1'b0, 1'b1);
      check("bp_in_ready", 32'(bif.in_ready), 32'd0);
      tick();
      check("bp_hold", 32'(bif.outA_data), 32'h3);
      check("bp_hold_v", 32'(bif.outA_valid), 32'd1);

      // independence: B accepts while A is stalled
      drive(4'hC, 1'b1, 1'b1);
      check("ind_ready", 32'(bif.in_ready), 32'd1);
      tick();
      check("ind_b_data", 32'(bif.outB_data), 32'hC);
      check("ind_b_valid", 32'(bif.outB_valid), 32'd1);
      check("ind_a_hold", 32'(bif.outA_data), 32'h3);

      // release A: 3 drains and 7 loads on the same edge
      bif.outA_ready = 1'b1;
      drive(4'h7, 1'b0, 1'b1);
      check("bp_rel_ready", 32'(bif.in_ready), 32'd1);
      tick();
      check("bp_a_new", 32'(bif.outA_data), 32'h7);
      check("bp_a_new_v", 32'(bif.outA_valid), 32'd1);
      drive(4'h0, 1'b0, 1'b0);
      tick();
      check("bp_a_empty", 32'(bif.outA_valid), 32'd0);

      // in_sel toggling without in_valid changes nothing
      drive(4'hF, 1'b1, 1'b0);
      tick();
      drive(4'hE, 1'b0, 1'b0);
      tick();
      check("sel_idle_a", 32'(bif.outA_valid), 32'd0);
      check("sel_idle_b", 32'(bif.outB_valid), 32'd0);

      // streaming 0..F into B
      bif.outB_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         drive(4'(i), 1'b1, 1'b1);
         check("st_ready", 32'(bif.in_ready), 32'd1);
         tick();
         check("st_b_data", 32'(bif.outB_data), 32'(i));
         check("st_b_valid", 32'(bif.outB_valid), 32'd1);
      end
      drive(4'h0, 1'b0, 1'b0);
      tick();
      check("st_b_done", 32'(bif.outB_valid), 32'd0);

      // asynchronous reset with both slots full
      bif.outA_ready = 1'b0;
      bif.outB_ready = 1'b0;
      drive(4'h9, 1'b0, 1'b1);
      tick();
      drive(4'h6, 1'b1, 1'b1);
      tick();
      drive(4'h0, 1'b0, 1'b0);
      check("pre_rst_a", 32'(bif.outA_valid), 32'd1);
      check("pre_rst_b", 32'(bif.outB_data), 32'h6);
      Rst = 1'b1;
      #1;
      check("arst_a_valid", 32'(bif.outA_valid), 32'd0);
      check("arst_b_valid", 32'(bif.outB_valid), 32'd0);
      check("arst_a_data", 32'(bif.outA_data), 32'h0);
      check("arst_b_data", 32'(bif.outB_data), 32'h0);
      tick();
      Rst = 1'b0;
      #1;
      check("arst_in_ready", 32'(bif.in_ready), 32'd1);
      drive(4'hB, 1'b0, 1'b1);
      tick();
      check("post_rst_a", 32'(bif.outA_data), 32'hB);
      drive(4'h0, 1'b0, 1'b0);

`ifdef DEMUX_STATS_EN
      Rst = 1'b1;
      #1;
      check("cnt_rst_a", 32'(bif.cntA), 32'd0);
      check("cnt_rst_b", 32'(bif.cntB), 32'd0);
      tick();
      Rst = 1'b0;
      bif.outA_ready = 1'b1;
      bif.outB_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(4'(i + 1), 1'b0, 1'b1);
         tick();
      end
      drive(4'h0, 1'b0, 1'b0);
      tick();
      check("cnt_a_sat", 32'(bif.cntA), 32'd3);
      check("cnt_b_zero", 32'(bif.cntB), 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/demux_4bit_1to2_buf.md
# demux_4bit_1to2_buf

Buffered 1-to-2 demultiplexer that steers a 4-bit datapath word to one of two downstream consumers according to a select bit. It is the inverse of the datapath 2-to-1 selectors: one producer fans out to two consumers instead of two producers feeding one consumer. Each output has a one-entry holding register with valid/ready handshaking, so a stalled consumer never corrupts or drops data. It sits between a datapath stage and two independently stalling destinations, for example a write-back path and a debug/trace port.

## Interface
Parameters:
- WIDTH, 4, data word width in bits; legal range 1..32.
- CNT_W, 8, width of each transfer counter; present only with DEMUX_STATS_EN.

Ports:
- Clk  in  1  rising-edge clock.
- Rst  in  1  reset; asynchronous, active-high.
- in_data  in  WIDTH  word to route.
- in_sel  in  1  0 routes to channel A, 1 routes to channel B.
- in_valid  in  1  in_data/in_sel are valid.
- in_ready  out  1  block accepts the word this cycle.
- outA_data  out  WIDTH  channel A word.
- outA_valid  out  1  channel A holds a word.
- outA_ready  in  1  channel A consumer accepts.
- outB_data / outB_valid / outB_ready: same as channel A, for channel B.
- cntA, cntB  out  CNT_W  count of words delivered per channel; present only with DEMUX_STATS_EN.

## Operation
- Each channel has a one-entry slot with two states, EMPTY (valid=0) and FULL (valid=1).
- Input transfer: in_valid && in_ready on a rising Clk edge.
- Output transfer: outX_valid && outX_ready on a rising Clk edge.
- in_ready = !sel_valid || sel_ready, where sel_valid and sel_ready are outX_valid and outX_ready of the channel chosen by in_sel. The path is combinational from in_sel and outX_ready. in_ready does not depend on in_valid.
- On an input transfer, the selected slot loads in_data and goes to (or stays) FULL. The unselected slot is unaffected.
- Slot transitions:
  - EMPTY to FULL on load.
  - FULL to EMPTY on drain without load.
  - FULL stays FULL on a simultaneous drain and load, and the data is replaced by the new word.
  - FULL stays FULL with data unchanged when neither event occurs.
- While outX_valid=1 and outX_ready=0, outX_data is held stable.
- Words are delivered in order within each channel. No ordering is guaranteed between channels.
- A stall on one channel never blocks input addressed to the other channel.
- in_sel is sampled only on an input transfer. in_sel changing while in_valid=0 has no effect.

## Timing
- Latency: a word accepted at edge N appears on outX at edge N (valid after N). It can be consumed at edge N+1 at the earliest.
- Throughput: one word per cycle sustained per channel while its consumer holds ready=1.
- Reset values: outA_valid=0, outB_valid=0, outA_data=0, outB_data=0, cntA=0, cntB=0.
- in_ready is 1 after reset because both slots are empty.
- Reset asserted mid-operation empties both slots immediately and asynchronously. Any buffered words are discarded. The first edge after Rst deasserts behaves as from a cold start.
- No output is combinationally dependent on in_data.

## Configuration
- DEMUX_STATS_EN defined:
  - cntA and cntB exist.
  - Each increments by 1 on an output transfer of its channel.
  - Each saturates at 2^CNT_W-1 and does not wrap.
  - Both reset to 0.
- DEMUX_STATS_EN undefined: the counter ports and logic are absent, and datapath behaviour is otherwise identical.

## Structure
- Shared package demux_pkg:
  - CH_A=1'b0 and CH_B=1'b1 channel-select constants.
  - Slot state encoding SLOT_EMPTY/SLOT_FULL.
  - Default WIDTH=4.
- Sub-module demux_slot:
  - One-entry valid/ready register with load, data-in, data-out, valid and ready ports.
  - Instantiated twice, once per channel.
- The top level holds the select decode, the in_ready mux and the optional counters.

## Test plan
- Reset: assert Rst mid-stream with both slots full -> outA_valid=outB_valid=0 and data=0 immediately; in_ready=1 after release.
- Basic routing: send 4'hA with sel=0, then 4'h5 with sel=1, both consumers ready -> outA_data=4'hA one cycle after acceptance, outB_data=4'h5 the following cycle; no cross-delivery.
- Back-pressure: outA_ready=0, send 4'h3 then 4'h7 to A -> first accepted, in_ready=0 for the second; outA_data holds 4'h3; after outA_ready=1, 4'h3 drains and 4'h7 is accepted that same edge.
- Independence: A stalled and full, send 4'hC to B -> in_ready=1 and B receives 4'hC while A still holds its word.
- Streaming: 16 back-to-back words 0..F to B with outB_ready=1 -> in_ready never drops; outB delivers 0..F in order at one per cycle.
- Stats (DEMUX_STATS_EN, CNT_W=2): deliver 5 words on A -> cntA=3 (saturated), cntB=0.
